// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: state encoding, index-width helper and default timing for the RO scheduler.
package ro_meas_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, CLEAR, GATE, DRAIN, OUT} state_t;
    localparam int DEF_NUM_OSC    = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_WINDOW_CYC = 1024;
    localparam int DEF_DRAIN_CYC  = 3;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ro_meas_chan_pick.sv
// ro_meas_chan_pick: finds the lowest set mask bit at or above a start index.
module ro_meas_chan_pick
    import ro_meas_pkg::*;
#(
    parameter int NUM_OSC = DEF_NUM_OSC,
    parameter int OSC_W   = idx_w(NUM_OSC)
) (
    input  logic [NUM_OSC-1:0] mask,
    input  logic [OSC_W:0]     from,
    output logic [OSC_W-1:0]   pos,
    output logic               found
);
    // Scan high to low so the last hit wins, leaving the lowest qualifying bit.
    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int i = NUM_OSC - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                pos   = OSC_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ro_meas_scheduler.sv
// ro_meas_scheduler: round-robin RO measurement sequencer; RO_MEAS_AVG_EN enables 4-window averaging.
module ro_meas_scheduler
    import ro_meas_pkg::*;
#(
    parameter int NUM_OSC    = DEF_NUM_OSC,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
    localparam int OSC_W     = idx_w(NUM_OSC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic [NUM_OSC-1:0] chan_mask,
    output logic [OSC_W-1:0]   osc_sel,
    output logic [NUM_OSC-1:0] osc_en,
    output logic               cnt_clr,
    output logic               cnt_gate,
    input  logic [CNT_W-1:0]   cnt_value,
    input  logic               cnt_ovf,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_data,
    output logic [OSC_W-1:0]   res_chan,
    output logic               res_ovf,
    output logic               busy
);
    localparam int MAX_SW  = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int MAX_CYC = (MAX_SW > DRAIN_CYC) ? MAX_SW : DRAIN_CYC;
    localparam int CW      = idx_w(MAX_CYC);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_val;
    logic               cnt_ld, done, take_mask, cap, last_win, fin_ovf;
    logic [NUM_OSC-1:0] mask_q;
    logic [OSC_W-1:0]   chan, chan_n, first_pos, next_pos;
    logic [OSC_W:0]     chan_inc;
    logic               first_ok, next_ok;
    logic [CNT_W-1:0]   fin_data;

    assign done     = (cnt == '0);
    assign chan_inc = (OSC_W+1)'(chan) + (OSC_W+1)'(1);
    assign osc_sel  = chan;
    assign res_chan = chan;

    ro_meas_chan_pick #(.NUM_OSC(NUM_OSC)) u_first (
        .mask(chan_mask), .from('0), .pos(first_pos), .found(first_ok)
    );
    ro_meas_chan_pick #(.NUM_OSC(NUM_OSC)) u_next (
        .mask(mask_q), .from(chan_inc), .pos(next_pos), .found(next_ok)
    );

`ifdef RO_MEAS_AVG_EN
    logic [1:0]       rep;
    logic [CNT_W+1:0] acc, sum;
    logic             acc_ovf, sum_ovf;
    assign sum      = ((rep == 2'd0) ? '0 : acc) + (CNT_W+2)'(cnt_value);
    assign sum_ovf  = ((rep != 2'd0) && acc_ovf) || cnt_ovf;
    assign last_win = (rep == 2'd3);
    assign fin_data = sum_ovf ? '1 : sum[CNT_W+1:2];
    assign fin_ovf  = sum_ovf;
    // Accumulate the four windows of a channel; rep wraps back to 0 after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep     <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (cap) begin
            rep     <= rep + 2'd1;
            acc     <= sum;
            acc_ovf <= sum_ovf;
        end
    end
`else
    assign last_win = 1'b1;
    assign fin_data = cnt_ovf ? '1 : cnt_value;
    assign fin_ovf  = cnt_ovf;
`endif

    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Next state, phase-counter loads and decoded outputs.
    always_comb begin
        state_n   = state;
        cnt_ld    = 1'b0;
        cnt_val   = '0;
        chan_n    = chan;
        take_mask = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: if ((start || continuous) && first_ok) begin
                state_n   = SETTLE;
                take_mask = 1'b1;
                chan_n    = first_pos;
                cnt_ld    = 1'b1;
                cnt_val   = CW'(SETTLE_CYC - 1);
            end
            SETTLE: if (done) state_n = CLEAR;
            CLEAR: begin
                state_n = GATE;
                cnt_ld  = 1'b1;
                cnt_val = CW'(WINDOW_CYC - 1);
            end
            GATE: if (done) begin
                state_n = DRAIN;
                cnt_ld  = 1'b1;
                cnt_val = CW'(DRAIN_CYC - 1);
            end
            DRAIN: if (done) begin
                cap     = 1'b1;
                state_n = last_win ? OUT : CLEAR;
            end
            OUT: if (res_ready) begin
                cnt_val = CW'(SETTLE_CYC - 1);
                if (next_ok) begin
                    state_n = SETTLE;
                    chan_n  = next_pos;
                    cnt_ld  = 1'b1;
                end else if (continuous && first_ok) begin
                    state_n   = SETTLE;
                    take_mask = 1'b1;
                    chan_n    = first_pos;
                    cnt_ld    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy      = (state != IDLE);
        cnt_clr   = (state == CLEAR);
        cnt_gate  = (state == GATE);
        res_valid = (state == OUT);
        osc_en    = (busy && state != OUT) ? (NUM_OSC'(1) << chan) : '0;
    end

    // Shared phase down-counter, channel/mask latches and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            chan     <= '0;
            mask_q   <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            cnt  <= cnt_ld ? cnt_val : (done ? cnt : cnt - CW'(1));
            chan <= chan_n;
            if (take_mask) mask_q <= chan_mask;
            if (cap && last_win) begin
                res_data <= fin_data;
                res_ovf  <= fin_ovf;
            end
        end
    end
endmodule
